// File: rtl/gray_counter_n_pkg.sv
// Shared constants and binary/Gray conversion helpers for the Gray counter.
// The helpers work on 32 bits; narrower callers zero-extend and truncate.
package gray_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;
  localparam int   MAX_WIDTH = 32;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix XOR from the MSB down; a zero-extended Gray code stays zero above WIDTH.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] gray);
    logic [MAX_WIDTH-1:0] bin;
    bin[MAX_WIDTH-1] = gray[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_counter_n_if.sv
// Control and result bundle of the Gray counter; clock and reset stay plain ports.
interface gray_counter_n_if #(
  parameter int WIDTH = 4
) ();

  logic             clk_en;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] gray_out;
  logic [WIDTH-1:0] bin_out;
  logic             tc;

  modport master (
    output clk_en, dir, load, load_val,
    input  gray_out, bin_out, tc
  );

  modport slave (
    input  clk_en, dir, load, load_val,
    output gray_out, bin_out, tc
  );

endinterface

// File: rtl/gray_counter_n_step.sv
// Next-count and terminal detection for one step of the binary count.
module gray_step
  import gray_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] bin,
  input  logic             dir,
  output logic [WIDTH-1:0] next_bin,
  output logic             at_term
);

  always_comb begin
    at_term  = (dir == DIR_UP) ? (&bin) : ~(|bin);
    next_bin = bin;
    // Saturating counters park on the terminal value instead of wrapping.
    if (!(SATURATE && at_term)) begin
      if (dir == DIR_UP) begin
        next_bin = bin + WIDTH'(1);
      end else begin
        next_bin = bin - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/gray_counter_n.sv
// Parametrised up/down Gray counter with synchronous load, wrap or saturate,
// registered binary/Gray outputs and a single-cycle terminal-count pulse.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  gray_counter_n_if.slave  bus
);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             tc_q;
  logic [WIDTH-1:0] next_bin;
  logic             at_term;

  gray_step #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_step (
    .bin      (bin_q),
    .dir      (bus.dir),
    .next_bin (next_bin),
    .at_term  (at_term)
  );

  // Both registers are loaded from the same binary value so the Gray
  // register always equals the conversion of the binary one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      tc_q   <= 1'b0;
    end else if (bus.load) begin
      bin_q  <= bus.load_val;
      gray_q <= WIDTH'(bin2gray(MAX_WIDTH'(bus.load_val)));
      tc_q   <= 1'b0;
    end else if (bus.clk_en) begin
      bin_q  <= next_bin;
      gray_q <= WIDTH'(bin2gray(MAX_WIDTH'(next_bin)));
      tc_q   <= at_term;
    end else begin
      tc_q   <= 1'b0;
    end
  end

  assign bus.bin_out  = bin_q;
  assign bus.gray_out = gray_q;
  assign bus.tc       = tc_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Directed and randomised checks of gray_counter_n in wrap (W4, W8) and saturate (W3) builds.
module tb_gray_counter_n;
  import gray_pkg::*;

  logic clk;
  logic rst;

  gray_counter_n_if #(.WIDTH(4)) if_a ();
  gray_counter_n_if #(.WIDTH(3)) if_b ();
  gray_counter_n_if #(.WIDTH(8)) if_c ();

  gray_counter_n #(.WIDTH(4), .SATURATE(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  gray_counter_n #(.WIDTH(3), .SATURATE(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  gray_counter_n #(.WIDTH(8), .SATURATE(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  localparam logic [3:0] G4 [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                     4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  int checks_total;
  int checks_passed;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      checks_passed++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic check_a(input string tag, input logic [3:0] b, input logic [3:0] g, input logic t);
    check({tag, ".bin"},  32'(if_a.bin_out),  32'(b));
    check({tag, ".gray"}, 32'(if_a.gray_out), 32'(g));
    check({tag, ".tc"},   32'(if_a.tc),       32'(t));
  endtask

  task automatic check_b(input string tag, input logic [2:0] b, input logic [2:0] g, input logic t);
    check({tag, ".bin"},  32'(if_b.bin_out),  32'(b));
    check({tag, ".gray"}, 32'(if_b.gray_out), 32'(g));
    check({tag, ".tc"},   32'(if_b.tc),       32'(t));
  endtask

  initial begin
    logic [7:0] exp_c;
    logic [7:0] prev_gray;
    logic       c_load, c_en, c_dir;
    logic [7:0] c_val;
    logic       exp_tc;
    checks_total  = 0;
    checks_passed = 0;
    rst = 1'b0;
    if_a.clk_en = 0; if_a.dir = 1; if_a.load = 0; if_a.load_val = '0;
    if_b.clk_en = 0; if_b.dir = 1; if_b.load = 0; if_b.load_val = '0;
    if_c.clk_en = 0; if_c.dir = 1; if_c.load = 0; if_c.load_val = '0;

    #3;
    check_a("reset_a", 4'h0, 4'h0, 1'b0);
    check_b("reset_b", 3'h0, 3'h0, 1'b0);
    #5;
    rst = 1'b1;

    // Up count through a full cycle and one step past the wrap.
    if_a.clk_en = 1; if_a.dir = DIR_UP;
    for (int k = 1; k <= 17; k++) begin
      step();
      check_a($sformatf("up%0d", k), 4'(k % 16), G4[k % 16], k == 16);
    end

    // Down count from reset wraps to all-ones.
    if_a.clk_en = 0;
    step();
    pulse_reset();
    if_a.clk_en = 1; if_a.dir = DIR_DOWN;
    step(); check_a("down1", 4'hF, 4'h8, 1'b1);
    step(); check_a("down2", 4'hE, 4'h9, 1'b0);

    // Load wins over a simultaneous enable.
    if_a.load = 1; if_a.load_val = 4'hA; if_a.dir = DIR_DOWN;
    step(); check_a("load_en", 4'hA, 4'hF, 1'b0);
    if_a.load = 0; if_a.dir = DIR_UP;
    step(); check_a("ld_up1", 4'hB, 4'hE, 1'b0);
    step(); check_a("ld_up2", 4'hC, 4'hA, 1'b0);
    step(); check_a("ld_up3", 4'hD, 4'hB, 1'b0);
    step(); check_a("ld_up4", 4'hE, 4'h9, 1'b0);
    step(); check_a("ld_up5", 4'hF, 4'h8, 1'b0);
    step(); check_a("ld_wrap", 4'h0, 4'h0, 1'b1);

    // Hold clears tc and keeps the count.
    if_a.clk_en = 0;
    step(); check_a("hold", 4'h0, 4'h0, 1'b0);

    // Loading the terminal value gives no tc; the next count wraps.
    if_a.load = 1; if_a.load_val = 4'hF;
    step(); check_a("ld_term", 4'hF, 4'h8, 1'b0);
    if_a.load = 0; if_a.clk_en = 1;
    step(); check_a("term_wrap", 4'h0, 4'h0, 1'b1);

    // Asynchronous reset between edges, then resume from zero.
    step(); check_a("pre_rst", 4'h1, 4'h1, 1'b0);
    #3 rst = 1'b0;
    #1 check_a("async_rst", 4'h0, 4'h0, 1'b0);
    #2 rst = 1'b1;
    step(); check_a("resume", 4'h1, 4'h1, 1'b0);
    if_a.clk_en = 0;

    // Saturating 3-bit build.
    if_b.load = 1; if_b.load_val = 3'd5;
    step(); check_b("sat_ld", 3'd5, 3'd7, 1'b0);
    if_b.load = 0; if_b.clk_en = 1; if_b.dir = DIR_UP;
    step(); check_b("sat1", 3'd6, 3'd5, 1'b0);
    step(); check_b("sat2", 3'd7, 3'd4, 1'b0);
    step(); check_b("sat3", 3'd7, 3'd4, 1'b1);
    step(); check_b("sat4", 3'd7, 3'd4, 1'b1);
    if_b.dir = DIR_DOWN;
    step(); check_b("sat_dn", 3'd6, 3'd5, 1'b0);
    if_b.load = 1; if_b.load_val = 3'd0;
    step(); check_b("sat_ld0", 3'd0, 3'd0, 1'b0);
    if_b.load = 0;
    step(); check_b("sat_lo", 3'd0, 3'd0, 1'b1);
    if_b.clk_en = 0;
    step(); check_b("sat_hold", 3'd0, 3'd0, 1'b0);

    // Random 8-bit run with an independent reference count.
    exp_c     = 8'h00;
    prev_gray = if_c.gray_out;
    check("c_start", 32'(if_c.bin_out), 32'(exp_c));
    for (int n = 0; n < 10000; n++) begin
      c_load = ($urandom_range(0, 15) == 0);
      c_en   = ($urandom_range(0, 3) != 0);
      c_dir  = 1'($urandom_range(0, 1));
      c_val  = 8'($urandom_range(0, 255));
      if_c.load = c_load; if_c.clk_en = c_en; if_c.dir = c_dir; if_c.load_val = c_val;
      exp_tc = 1'b0;
      if (c_load) begin
        exp_c = c_val;
      end else if (c_en) begin
        exp_tc = c_dir ? (exp_c == 8'hFF) : (exp_c == 8'h00);
        exp_c  = c_dir ? exp_c + 8'd1 : exp_c - 8'd1;
      end
      step();
      check("rnd_bin", 32'(if_c.bin_out), 32'(exp_c));
      check("rnd_tc", 32'(if_c.tc), 32'(exp_tc));
      check("rnd_g2b", gray2bin(32'(if_c.gray_out)), 32'(if_c.bin_out));
      if (!c_load && (if_c.gray_out != prev_gray)) begin
        check("rnd_hamming", 32'($countones(if_c.gray_out ^ prev_gray)), 32'd1);
      end
      prev_gray = if_c.gray_out;
    end
    if_c.clk_en = 0; if_c.load = 0;

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
